elevator_ctrl_n: RTL and testbench

- Parametrised N-floor elevator car controller; successor to the fixed 3-state STAY/DOWN/UP controller.
- Latches hall and cab requests into a pending register and sweeps the car using a SCAN (collective) policy.
- Times floor-to-floor travel and door dwell, supports door hold (obstruction), and reports position and direction to the display and motor layers.

---
 rtl/elevator_pkg.sv | 16 +
 rtl/elevator_req_scan.sv | 29 ++
 rtl/elevator_ctrl_n.sv | 153 +++++++++++++++
 tb/tb_elevator_ctrl_n.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator car controller.
// Direction and FSM state constants used by the controller and its helpers.
package elevator_pkg;

    localparam logic [1:0] S_STAY = 2'd0;
    localparam logic [1:0] S_DOWN = 2'd1;
    localparam logic [1:0] S_UP   = 2'd2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t MOVE_UP   = 2'd1;
    localparam state_t MOVE_DOWN = 2'd2;
    localparam state_t DOOR      = 2'd3;

endpackage

// File: rtl/elevator_req_scan.sv
// Request scan for the elevator controller.
// Reports whether pending requests lie above, below or at the current floor.
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = $clog2(FLOORS)
) (
    input  logic [FLOORS-1:0]  pending,
    input  logic [FLOOR_W-1:0] cur_floor,
    output logic               above,
    output logic               below,
    output logic               here
);

    // reduce pending bits on either side of the car
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i]) begin
                if (i > int'(cur_floor)) above = 1'b1;
                if (i < int'(cur_floor)) below = 1'b1;
            end
        end
        here = pending[cur_floor];
    end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator car controller with SCAN sweep policy.
// Latches requests, times travel and door dwell, honours door hold.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int FLOORS   = 8,
    parameter int FLOOR_W  = $clog2(FLOORS),
    parameter int MOVE_CYC = 4,
    parameter int DOOR_CYC = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOORS-1:0]  req_vec,
    input  logic               door_hold,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [1:0]         dir,
    output logic               moving,
    output logic               door_open,
    output logic               arrive,
    output logic [FLOORS-1:0]  pending
);

    localparam int MCW = (MOVE_CYC > 1) ? $clog2(MOVE_CYC) : 1;
    localparam int DCW = $clog2(DOOR_CYC + 1);

    state_t             state, nxt_state;
    logic [FLOOR_W-1:0] floor_q, nxt_floor, step_floor;
    logic [1:0]         dir_q, nxt_dir;
    logic [MCW-1:0]     mcnt, nxt_mcnt;
    logic [DCW-1:0]     dcnt, nxt_dcnt;
    logic [FLOORS-1:0]  pend_q, clr;
    logic               arrive_q, nxt_arrive;
    logic               above, below, here;
    logic               go_up, go_down;

    elevator_req_scan #(
        .FLOORS (FLOORS),
        .FLOOR_W(FLOOR_W)
    ) u_scan (
        .pending  (pend_q),
        .cur_floor(floor_q),
        .above    (above),
        .below    (below),
        .here     (here)
    );

    // floor the car reaches at the end of the current move
    always_comb begin
        if (state == MOVE_DOWN) step_floor = floor_q - FLOOR_W'(1);
        else                    step_floor = floor_q + FLOOR_W'(1);
    end

    // sweep choice at door close: keep direction, else reverse
    always_comb begin
        go_up   = above && ((dir_q != S_DOWN) || !below);
        go_down = below && !go_up;
    end

    // next-state, timer and clear-mask logic
    always_comb begin
        nxt_state  = state;
        nxt_floor  = floor_q;
        nxt_dir    = dir_q;
        nxt_mcnt   = mcnt;
        nxt_dcnt   = dcnt;
        nxt_arrive = 1'b0;
        clr        = '0;
        unique case (state)
            IDLE: begin
                nxt_mcnt = '0;
                if (here) begin
                    nxt_state       = DOOR;
                    nxt_dcnt        = DCW'(DOOR_CYC);
                    nxt_arrive      = 1'b1;
                    clr[floor_q]    = 1'b1;
                end else if (above) begin
                    nxt_state = MOVE_UP;
                    nxt_dir   = S_UP;
                end else if (below) begin
                    nxt_state = MOVE_DOWN;
                    nxt_dir   = S_DOWN;
                end else begin
                    nxt_dir = S_STAY;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (mcnt == MCW'(MOVE_CYC - 1)) begin
                    nxt_mcnt  = '0;
                    nxt_floor = step_floor;
                    if (pend_q[step_floor]) begin
                        nxt_state       = DOOR;
                        nxt_dcnt        = DCW'(DOOR_CYC);
                        nxt_arrive      = 1'b1;
                        clr[step_floor] = 1'b1;
                    end
                end else begin
                    nxt_mcnt = mcnt + MCW'(1);
                end
            end
            DOOR: begin
                clr[floor_q] = 1'b1;
                if (door_hold || req_vec[floor_q]) begin
                    nxt_dcnt = DCW'(DOOR_CYC);
                end else if (dcnt <= DCW'(1)) begin
                    nxt_dcnt = '0;
                    nxt_mcnt = '0;
                    if (go_up) begin
                        nxt_state = MOVE_UP;
                        nxt_dir   = S_UP;
                    end else if (go_down) begin
                        nxt_state = MOVE_DOWN;
                        nxt_dir   = S_DOWN;
                    end else begin
                        nxt_state = IDLE;
                        nxt_dir   = S_STAY;
                    end
                end else begin
                    nxt_dcnt = dcnt - DCW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // state, position, timers and pending requests
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            floor_q  <= '0;
            dir_q    <= S_STAY;
            mcnt     <= '0;
            dcnt     <= '0;
            pend_q   <= '0;
            arrive_q <= 1'b0;
        end else begin
            state    <= nxt_state;
            floor_q  <= nxt_floor;
            dir_q    <= nxt_dir;
            mcnt     <= nxt_mcnt;
            dcnt     <= nxt_dcnt;
            pend_q   <= (pend_q | req_vec) & ~clr;
            arrive_q <= nxt_arrive;
        end
    end

    assign cur_floor = floor_q;
    assign dir       = dir_q;
    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign door_open = (state == DOOR);
    assign arrive    = arrive_q;
    assign pending   = pend_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed bench for elevator_ctrl_n (default sizing plus a 1/1 timing copy).
// Vector table for the basic trip, hand sequences for sweep corner cases.
module tb_elevator_ctrl_n;
    import elevator_pkg::*;

    typedef struct {
        logic [7:0] req;
        logic       hold;
        logic [2:0] fl;
        logic [1:0] dr;
        logic       mv;
        logic       dop;
        logic       arr;
        logic [7:0] pd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_vec = '0;
    logic       door_hold = 1'b0;
    logic [2:0] cur_floor;
    logic [1:0] dir;
    logic       moving, door_open, arrive;
    logic [7:0] pending;

    logic [7:0] req1 = '0;
    logic [2:0] cur_floor1;
    logic [1:0] dir1;
    logic       moving1, door_open1, arrive1;
    logic [7:0] pending1;

    int total = 0;
    int bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    elevator_ctrl_n #(.FLOORS(8), .MOVE_CYC(4), .DOOR_CYC(6)) dut (
        .clk(clk), .rst_n(rst_n), .req_vec(req_vec), .door_hold(door_hold),
        .cur_floor(cur_floor), .dir(dir), .moving(moving),
        .door_open(door_open), .arrive(arrive), .pending(pending)
    );

    elevator_ctrl_n #(.FLOORS(8), .MOVE_CYC(1), .DOOR_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_vec(req1), .door_hold(1'b0),
        .cur_floor(cur_floor1), .dir(dir1), .moving(moving1),
        .door_open(door_open1), .arrive(arrive1), .pending(pending1)
    );

    // the car must never try to travel past either end of the shaft
    always @(negedge clk) begin
        if (rst_n && moving) begin
            total++;
            if ((dir == S_UP && cur_floor == 3'd7) ||
                (dir == S_DOWN && cur_floor == 3'd0)) begin
                bad++;
                $display("FAIL bound: moving dir=%0d at floor %0d", dir, cur_floor);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".floor"}, 32'(cur_floor), 32'(v.fl));
        chk({tag, ".dir"}, 32'(dir), 32'(v.dr));
        chk({tag, ".moving"}, 32'(moving), 32'(v.mv));
        chk({tag, ".door"}, 32'(door_open), 32'(v.dop));
        chk({tag, ".arrive"}, 32'(arrive), 32'(v.arr));
        chk({tag, ".pending"}, 32'(pending), 32'(v.pd));
    endtask

    function automatic vec_t mk(input logic [7:0] rq, input logic [2:0] f, input logic [1:0] d,
                                input logic m, input logic o, input logic a, input logic [7:0] p);
        vec_t v;
        v.req = rq; v.hold = 1'b0; v.fl = f; v.dr = d;
        v.mv = m; v.dop = o; v.arr = a; v.pd = p;
        return v;
    endfunction

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        req_vec = '0;
        door_hold = 1'b0;
        req1 = '0;
        tick();
        tick();
        chk_all(tag, mk(8'h00, 3'd0, S_STAY, 1'b0, 1'b0, 1'b0, 8'h00));
        rst_n = 1'b1;
    endtask

    task automatic wait_door(input string tag, input logic [2:0] f, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            if (door_open && cur_floor == f) hit = 1'b1;
        end
        chk({tag, ".reached"}, 32'(hit), 32'd1);
    endtask

    initial begin
        // basic trip 0 -> 2: expected trace edge by edge
        tbl.push_back(mk(8'h04, 3'd0, S_STAY, 1'b0, 1'b0, 1'b0, 8'h04));
        for (int e = 2; e <= 5; e++) tbl.push_back(mk(8'h00, 3'd0, S_UP, 1'b1, 1'b0, 1'b0, 8'h04));
        for (int e = 6; e <= 9; e++) tbl.push_back(mk(8'h00, 3'd1, S_UP, 1'b1, 1'b0, 1'b0, 8'h04));
        tbl.push_back(mk(8'h00, 3'd2, S_UP, 1'b0, 1'b1, 1'b1, 8'h00));
        for (int e = 11; e <= 15; e++) tbl.push_back(mk(8'h00, 3'd2, S_UP, 1'b0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(8'h00, 3'd2, S_STAY, 1'b0, 1'b0, 1'b0, 8'h00));

        do_reset("rst0");
        foreach (tbl[i]) begin
            req_vec = tbl[i].req;
            door_hold = tbl[i].hold;
            tick();
            chk_all($sformatf("trip.e%0d", i + 1), tbl[i]);
        end
        req_vec = '0;

        // request at the idle floor opens the door without moving
        do_reset("rst1");
        req_vec = 8'h01;
        tick();
        req_vec = '0;
        chk("here.latch", 32'(pending), 32'h01);
        tick();
        chk_all("here.open", mk(8'h00, 3'd0, S_STAY, 1'b0, 1'b1, 1'b1, 8'h00));
        tick_n(6);
        chk_all("here.close", mk(8'h00, 3'd0, S_STAY, 1'b0, 1'b0, 1'b0, 8'h00));

        // intermediate stop on the way up, passed floor waits for reverse sweep
        do_reset("rst2");
        req_vec = 8'h20;
        tick();
        req_vec = '0;
        tick_n(5);
        chk("mid.f1", 32'(cur_floor), 32'd1);
        req_vec = 8'h08;
        tick();
        req_vec = '0;
        chk("mid.pend", 32'(pending), 32'h28);
        tick_n(7);
        chk_all("mid.stop3", mk(8'h00, 3'd3, S_UP, 1'b0, 1'b1, 1'b1, 8'h20));
        req_vec = 8'h02;
        tick();
        req_vec = '0;
        chk("mid.pend1", 32'(pending), 32'h22);
        chk("mid.arr1", 32'(arrive), 32'd0);
        tick_n(5);
        chk_all("mid.resume", mk(8'h00, 3'd3, S_UP, 1'b1, 1'b0, 1'b0, 8'h22));
        tick_n(8);
        chk_all("mid.stop5", mk(8'h00, 3'd5, S_UP, 1'b0, 1'b1, 1'b1, 8'h02));
        tick_n(6);
        chk_all("mid.rev", mk(8'h00, 3'd5, S_DOWN, 1'b1, 1'b0, 1'b0, 8'h02));
        tick_n(16);
        chk_all("mid.stop1", mk(8'h00, 3'd1, S_DOWN, 1'b0, 1'b1, 1'b1, 8'h00));
        tick_n(6);
        chk_all("mid.idle", mk(8'h00, 3'd1, S_STAY, 1'b0, 1'b0, 1'b0, 8'h00));

        // door hold at floor 4, then a same-floor request restarts dwell
        do_reset("rst3");
        req_vec = 8'h10;
        tick();
        req_vec = '0;
        tick_n(17);
        chk_all("hold.open", mk(8'h00, 3'd4, S_UP, 1'b0, 1'b1, 1'b1, 8'h00));
        door_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("hold.c%0d", i), 32'(door_open), 32'd1);
        end
        door_hold = 1'b0;
        tick_n(5);
        chk("hold.last", 32'(door_open), 32'd1);
        tick();
        chk_all("hold.shut", mk(8'h00, 3'd4, S_STAY, 1'b0, 1'b0, 1'b0, 8'h00));
        req_vec = 8'h10;
        tick();
        req_vec = '0;
        chk("re.latch", 32'(pending), 32'h10);
        tick();
        chk("re.open", 32'(door_open), 32'd1);
        tick_n(2);
        req_vec = 8'h10;
        tick();
        req_vec = '0;
        chk("re.nolatch", 32'(pending), 32'h00);
        tick_n(5);
        chk("re.still", 32'(door_open), 32'd1);
        tick();
        chk_all("re.shut", mk(8'h00, 3'd4, S_STAY, 1'b0, 1'b0, 1'b0, 8'h00));

        // tie from idle at floor 3: up first, then down, then stay
        do_reset("rst4");
        req_vec = 8'h08;
        tick();
        req_vec = '0;
        wait_door("tie.to3", 3'd3, 40);
        tick_n(6);
        chk("tie.idle3", 32'(door_open | moving), 32'd0);
        req_vec = 8'h42;
        tick();
        req_vec = '0;
        tick();
        chk("tie.dir0", 32'(dir), 32'(S_UP));
        wait_door("tie.to6", 3'd6, 60);
        chk("tie.dir6", 32'(dir), 32'(S_UP));
        wait_door("tie.to1", 3'd1, 80);
        chk("tie.dir1", 32'(dir), 32'(S_DOWN));
        tick_n(6);
        chk_all("tie.end", mk(8'h00, 3'd1, S_STAY, 1'b0, 1'b0, 1'b0, 8'h00));

        // reset while travelling between floors 2 and 3
        do_reset("rst5");
        req_vec = 8'h20;
        tick();
        req_vec = '0;
        tick_n(11);
        chk_all("mr.pre", mk(8'h00, 3'd2, S_UP, 1'b1, 1'b0, 1'b0, 8'h20));
        rst_n = 1'b0;
        tick();
        chk_all("mr.rst", mk(8'h00, 3'd0, S_STAY, 1'b0, 1'b0, 1'b0, 8'h00));
        rst_n = 1'b1;
        tick_n(3);
        chk_all("mr.after", mk(8'h00, 3'd0, S_STAY, 1'b0, 1'b0, 1'b0, 8'h00));

        // single-cycle move and single-cycle door
        do_reset("rst6");
        req1 = 8'h04;
        tick();
        req1 = '0;
        tick();
        chk("fast.mv", 32'(moving1), 32'd1);
        tick();
        chk("fast.f1", 32'(cur_floor1), 32'd1);
        chk("fast.mv1", 32'(moving1), 32'd1);
        tick();
        chk("fast.f2", 32'(cur_floor1), 32'd2);
        chk("fast.door", 32'(door_open1), 32'd1);
        chk("fast.arr", 32'(arrive1), 32'd1);
        tick();
        chk("fast.shut", 32'(door_open1), 32'd0);
        chk("fast.dir", 32'(dir1), 32'(S_STAY));
        chk("fast.pend", 32'(pending1), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
